// File: rtl/oric_tape_pkg.sv
// Shared types and defaults for the Oric cassette encoder and
// a future decoder-side checker.
package oric_tape_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tape_state_t;

    localparam int DATA_BITS       = 8;
    localparam int HALF_CYCLES_DEF = 2496;
    localparam int STOP_BITS_DEF   = 4;
endpackage

// File: rtl/tape_bit_shaper.sv
// One pulse cycle per bit: HIGH for H clocks, then LOW for H (bit 1)
// or 2H (bit 0). bit_last flags the final LOW clock.
module tape_bit_shaper
    import oric_tape_pkg::*;
#(
    parameter int HALF_CYCLES = HALF_CYCLES_DEF
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic bit_start,
    input  logic bit_val,
    output logic level,
    output logic bit_last
);
    localparam int CW = $clog2(2 * HALF_CYCLES);
    localparam logic [CW-1:0] H_LAST  = CW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] H2_LAST = CW'(2 * HALF_CYCLES - 1);

    logic          active;
    logic          high;
    logic          val;
    logic [CW-1:0] cnt;

    assign level    = active & high;
    assign bit_last = active & ~high & (cnt == (val ? H_LAST : H2_LAST));

    // A start on the last LOW clock chains the next bit with no gap.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            active <= 1'b0;
            high   <= 1'b0;
            val    <= 1'b0;
            cnt    <= '0;
        end else if (bit_start) begin
            active <= 1'b1;
            high   <= 1'b1;
            val    <= bit_val;
            cnt    <= '0;
        end else if (active) begin
            if (high && cnt == H_LAST) begin
                high <= 1'b0;
                cnt  <= '0;
            end else if (bit_last) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/oric_tape_encoder.sv
// Byte-to-cassette transmitter: frames bytes in Oric fast format
// (start, 8 data LSB first, odd parity, stop bits) for K7_TAPEIN.
module oric_tape_encoder
    import oric_tape_pkg::*;
#(
    parameter int HALF_CYCLES = HALF_CYCLES_DEF,
    parameter int STOP_BITS   = STOP_BITS_DEF
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] byte_i,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tape_out,
    output logic       busy
);
    localparam int SW = $clog2(STOP_BITS + 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);

    tape_state_t state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [SW-1:0] stop_cnt, stop_cnt_n;
    logic          accept;
    logic          bit_start;
    logic          bit_val;
    logic          bit_last;

    tape_bit_shaper #(
        .HALF_CYCLES(HALF_CYCLES)
    ) u_shaper (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .bit_start(bit_start),
        .bit_val  (bit_val),
        .level    (tape_out),
        .bit_last (bit_last)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            par      <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            par      <= par_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        par_n      = par;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        bit_start  = 1'b0;
        bit_val    = 1'b1;

        unique case (state)
            IDLE:    byte_ready = ~reset;
            STOP:    byte_ready = ~reset & bit_last & (stop_cnt == STOP_LAST);
            default: byte_ready = 1'b0;
        endcase

        accept = byte_valid & byte_ready;

        // The FSM names the bit now on the wire; the next bit's value
        // is handed to the shaper on the current bit's last clock.
        if (accept) begin
            state_n   = START;
            shreg_n   = byte_i;
            par_n     = ~^byte_i;
            bit_start = 1'b1;
            bit_val   = 1'b0;
        end else if (bit_last) begin
            unique case (state)
                START: begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    bit_start = 1'b1;
                    bit_val   = shreg[0];
                end
                DATA: begin
                    shreg_n   = shreg >> 1;
                    bit_start = 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        state_n = PARITY;
                        bit_val = par;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        bit_val   = shreg[1];
                    end
                end
                PARITY: begin
                    state_n    = STOP;
                    stop_cnt_n = '0;
                    bit_start  = 1'b1;
                end
                STOP: begin
                    if (stop_cnt == STOP_LAST) begin
                        state_n = IDLE;
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                        bit_start  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
